// File: rtl/adder_pkg.sv
// Shared definitions for the sequential adder: FSM state encoding, the
// chunk-count helper and the WIDTH/CHUNK legality check used at elaboration.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of CHUNK-bit slices needed to cover WIDTH bits.
    function automatic int chunk_count(input int width, input int chunk);
        return (chunk > 0) ? (width / chunk) : 1;
    endfunction

    // WIDTH must split into whole chunks and CHUNK must lie in 1..WIDTH.
    function automatic bit chunk_cfg_ok(input int width, input int chunk);
        return (chunk >= 1) && (chunk <= width) && ((width % chunk) == 0);
    endfunction

endpackage

// File: rtl/adder_chunk.sv
// Combinational CHUNK-bit ripple-carry adder slice. Also exposes the carry
// into its top bit so the caller can derive signed overflow.
module adder_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    logic [CHUNK:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        assign sum[i]  = a[i] ^ b[i] ^ c[i];
        assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout  = c[CHUNK];
    assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/adder_seq.sv
// Multi-cycle adder/subtractor: resolves a WIDTH-bit add or subtract CHUNK
// bits per clock through one shared adder_chunk slice, with valid/ready
// handshakes on both sides.
// Optional feature macro: ADDER_SEQ_OVF_EN adds the signed Overflow output.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | in_ready=1; waiting for an operation to capture
// RUN   | one chunk per cycle, result shifted into SUM from the top
// DONE  | out_valid=1; SUM/Cout/Overflow held until out_ready
module adder_seq
    import adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C0,
    input  logic             SUB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] SUM,
    output logic             Cout
`ifdef ADDER_SEQ_OVF_EN
    ,
    output logic             Overflow
`endif
);

    localparam int NCHUNK = chunk_count(WIDTH, CHUNK);
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    if (!chunk_cfg_ok(WIDTH, CHUNK)) begin : g_cfg_check
        $error("adder_seq: WIDTH must be a multiple of CHUNK with 1 <= CHUNK <= WIDTH");
    end

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   sum_q;
    logic               carry_q;
    logic [IDXW-1:0]    idx_q;
    logic               cout_q;
    logic [CHUNK-1:0]   ch_sum;
    logic               ch_cout;
    logic               ch_cmsb;
    logic [WIDTH+CHUNK-1:0] sum_cat;
    logic               last_chunk;

    // Operands shift right each RUN cycle, so the active chunk is always at
    // bit 0 and no WIDTH-wide index mux is needed.
    adder_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a     (a_q[CHUNK-1:0]),
        .b     (b_q[CHUNK-1:0]),
        .cin   (carry_q),
        .sum   (ch_sum),
        .cout  (ch_cout),
        .c_msb (ch_cmsb)
    );

    assign sum_cat    = {ch_sum, sum_q};
    assign last_chunk = (idx_q == IDXW'(NCHUNK - 1));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last_chunk) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, chunk-serial accumulation and final carry latch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= A;
                        b_q     <= SUB ? ~B : B;
                        carry_q <= SUB ? 1'b1 : C0;
                        idx_q   <= '0;
                    end
                end
                RUN: begin
                    a_q     <= a_q >> CHUNK;
                    b_q     <= b_q >> CHUNK;
                    sum_q   <= sum_cat[WIDTH+CHUNK-1:CHUNK];
                    carry_q <= ch_cout;
                    idx_q   <= idx_q + 1'b1;
                    if (last_chunk) begin
                        cout_q <= ch_cout;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ADDER_SEQ_OVF_EN
    logic ovf_q;

    // Signed overflow from the top slice: carry into MSB xor carry out of MSB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if ((state == RUN) && last_chunk) begin
            ovf_q <= ch_cmsb ^ ch_cout;
        end
    end

    assign Overflow = ovf_q;
`else
    logic ch_cmsb_unused;
    assign ch_cmsb_unused = ch_cmsb;
`endif

    assign SUM  = sum_q;
    assign Cout = cout_q;

endmodule

// File: tb/tb_adder_seq.sv
// Bench for adder_seq: a 32/4 instance and a 4/4 instance share clock and
// reset; stimulus pushes hand-computed results into queues and per-instance
// monitors pop and compare on each result handshake.
module tb_adder_seq;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    logic        in_valid, in_ready, C0, SUB, out_valid, out_ready, Cout;
    logic [31:0] A, B, SUM;
    logic        in_valid4, in_ready4, C04, SUB4, out_valid4, out_ready4, Cout4;
    logic [3:0]  A4, B4, SUM4;
`ifdef ADDER_SEQ_OVF_EN
    logic        ovf, ovf4;
`endif

    adder_seq #(.WIDTH(32), .CHUNK(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .C0(C0), .SUB(SUB), .out_valid(out_valid),
        .out_ready(out_ready), .SUM(SUM), .Cout(Cout)
`ifdef ADDER_SEQ_OVF_EN
        , .Overflow(ovf)
`endif
    );

    adder_seq #(.WIDTH(4), .CHUNK(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
        .A(A4), .B(B4), .C0(C04), .SUB(SUB4), .out_valid(out_valid4),
        .out_ready(out_ready4), .SUM(SUM4), .Cout(Cout4)
`ifdef ADDER_SEQ_OVF_EN
        , .Overflow(ovf4)
`endif
    );

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        int          acc;
    } exp_t;

    exp_t q[$];
    exp_t q4[$];
    int   nvec = 0;
    int   nmis = 0;
    int   cyc  = 0;
    bit   seen = 0;
    bit   seen4 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor for the 32-bit instance.
    always @(negedge clk) begin : mon32
        exp_t e;
        if (rst) begin
            seen <= 1'b0;
        end else if (out_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_result32", 32'd1, 32'd0);
            end else begin
                if (!seen) begin
                    chk("latency32", 32'(cyc - q[0].acc), 32'd8);
                    seen <= 1'b1;
                end
                if (out_ready) begin
                    e = q.pop_front();
                    chk("sum32", SUM, e.sum);
                    chk("cout32", {31'd0, Cout}, {31'd0, e.cout});
`ifdef ADDER_SEQ_OVF_EN
                    chk("ovf32", {31'd0, ovf}, {31'd0, e.ovf});
`endif
                    seen <= 1'b0;
                end
            end
        end
    end

    // Monitor for the 4-bit instance.
    always @(negedge clk) begin : mon4
        exp_t e;
        if (rst) begin
            seen4 <= 1'b0;
        end else if (out_valid4) begin
            if (q4.size() == 0) begin
                chk("unexpected_result4", 32'd1, 32'd0);
            end else begin
                if (!seen4) begin
                    chk("latency4", 32'(cyc - q4[0].acc), 32'd1);
                    seen4 <= 1'b1;
                end
                if (out_ready4) begin
                    e = q4.pop_front();
                    chk("sum4", {28'd0, SUM4}, e.sum);
                    chk("cout4", {31'd0, Cout4}, {31'd0, e.cout});
`ifdef ADDER_SEQ_OVF_EN
                    chk("ovf4", {31'd0, ovf4}, {31'd0, e.ovf});
`endif
                    seen4 <= 1'b0;
                end
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic c0,
                         input logic sub, input logic [31:0] es, input logic ec, input logic eo);
        int g = 0;
        @(negedge clk);
        while (!in_ready && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (!in_ready) begin
            chk("issue_timeout32", {31'd0, in_ready}, 32'd1);
            return;
        end
        A = a; B = b; C0 = c0; SUB = sub; in_valid = 1'b1;
        q.push_back('{es, ec, eo, cyc + 1});
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic issue4(input logic [3:0] a, input logic [3:0] b, input logic c0,
                          input logic sub, input logic [3:0] es, input logic ec, input logic eo);
        int g = 0;
        @(negedge clk);
        while (!in_ready4 && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (!in_ready4) begin
            chk("issue_timeout4", {31'd0, in_ready4}, 32'd1);
            return;
        end
        A4 = a; B4 = b; C04 = c0; SUB4 = sub; in_valid4 = 1'b1;
        q4.push_back('{{28'd0, es}, ec, eo, cyc + 1});
        @(posedge clk);
        #1 in_valid4 = 1'b0;
    endtask

    task automatic drain();
        int g = 0;
        while ((q.size() != 0 || q4.size() != 0) && g < 300) begin
            @(negedge clk);
            g++;
        end
        if (q.size() != 0 || q4.size() != 0)
            chk("drain_timeout", 32'(q.size() + q4.size()), 32'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int g;
        rst = 1'b1;
        in_valid = 1'b0; A = '0; B = '0; C0 = 1'b0; SUB = 1'b0; out_ready = 1'b1;
        in_valid4 = 1'b0; A4 = '0; B4 = '0; C04 = 1'b0; SUB4 = 1'b0; out_ready4 = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_sum", SUM, 32'd0);
        chk("rst_cout", {31'd0, Cout}, 32'd0);
`ifdef ADDER_SEQ_OVF_EN
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        // Directed vectors, issued back to back with out_ready held high.
        issue(32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        issue(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        issue(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        issue(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 32'h2345_678A, 1'b0, 1'b0);
        issue(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
        issue(32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0);
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);
        issue(32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0);
        drain();

        // Back-pressure in DONE while in_valid is pulsed.
        out_ready = 1'b0;
        issue(32'hDEAD_BEEF, 32'h0000_0011, 1'b0, 1'b0, 32'hDEAD_BF00, 1'b0, 1'b0);
        g = 0;
        while (!out_valid && g < 50) begin
            @(negedge clk);
            g++;
        end
        chk("hold_reach_done", {31'd0, out_valid}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; A = 32'h0000_1111 * (i + 1); B = 32'h1; SUB = 1'b0;
            @(negedge clk);
            chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
            chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_sum", SUM, 32'hDEAD_BF00);
            chk("hold_cout", {31'd0, Cout}, 32'd0);
`ifdef ADDER_SEQ_OVF_EN
            chk("hold_ovf", {31'd0, ovf}, 32'd0);
`endif
        end
        @(posedge clk);
        #1 in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("post_done_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (12) @(negedge clk);
        chk("no_second_op", {31'd0, out_valid}, 32'd0);
        chk("queue_empty", 32'(q.size()), 32'd0);

        // Reset in the middle of RUN with idx=3.
        issue(32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        q.delete();
        #1;
        chk("midrun_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrun_in_ready", {31'd0, in_ready}, 32'd1);
        chk("midrun_sum", SUM, 32'd0);
        chk("midrun_cout", {31'd0, Cout}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        issue(32'h0000_0100, 32'h0000_0001, 1'b0, 1'b1, 32'h0000_00FF, 1'b1, 1'b0);
        drain();

        // Single-chunk instance.
        issue4(4'h8, 4'h8, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1);
        issue4(4'h3, 4'h4, 1'b0, 1'b0, 4'h7, 1'b0, 1'b0);
        issue4(4'h2, 4'h3, 1'b0, 1'b1, 4'hF, 1'b0, 1'b0);
        drain();

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/adder_seq.md
# adder_seq

Parametrised multi-cycle adder/subtractor for the datapath. It accepts one WIDTH-bit operation through a valid/ready handshake and resolves it CHUNK bits per clock through a small ripple-carry chunk adder. It returns the sum with carry-out and an optional signed-overflow flag through a second valid/ready handshake. It trades latency for area and is the generalised successor of the fixed 4-bit ripple adder used in the ALU.

## Interface
- WIDTH, 32, operand and sum width; must be a multiple of CHUNK.
- CHUNK, 4, bits resolved per cycle; 1 ≤ CHUNK ≤ WIDTH.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operation offered.
- in_ready  out  1  block can accept an operation.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- C0  in  1  carry-in; used only when SUB=0.
- SUB  in  1  1 = A − B, 0 = A + B + C0.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- SUM  out  WIDTH  result.
- Cout  out  1  final carry; for SUB=1, 1 means no borrow.
- Overflow  out  1  signed two's-complement overflow; present only with ADDER_SEQ_OVF_EN.

## Operation
- NCHUNK = WIDTH/CHUNK. FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid, capture A into the operand register and B into the operand register as B when SUB=0 or ~B when SUB=1.
  - Initialise carry to C0 when SUB=0 or 1 when SUB=1, clear the chunk index, and go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle, add chunk[idx] of both operands plus the carry.
  - Shift the chunk result into SUM from the top; after NCHUNK chunks the LSB chunk sits at bit 0.
  - Register the carry and increment idx.
  - After the chunk with idx=NCHUNK−1, latch Cout (and Overflow) and go to DONE.
- DONE:
  - out_valid=1; SUM, Cout and Overflow are held stable.
  - On out_ready, go to IDLE.
  - in_valid is ignored in DONE; in_ready=0.
- Arithmetic is modulo 2^WIDTH. Overflow = carry into the MSB XOR carry out of the MSB, taken from the last chunk.
- Reset (at any time, including mid-RUN) aborts the operation and returns to IDLE. No partial result is ever presented.
- Reset values:
  - State IDLE.
  - in_ready=1.
  - out_valid=0.
  - SUM=0, Cout=0, Overflow=0.
  - idx=0, carry=0.

## Timing
- The operation is accepted on edge T (in_valid and in_ready both high).
- out_valid rises after edge T+NCHUNK.
- The result leaves on the first edge with out_valid and out_ready both high. in_ready is 1 in the following cycle.
- Minimum issue interval is NCHUNK+2 cycles, when out_ready is held high.
- The combinational path is a CHUNK-bit ripple only; there is no WIDTH-bit carry path.
- While out_valid=0, SUM may show partial shifted data and must not be sampled.

## Configuration
- ADDER_SEQ_OVF_EN defined:
  - Overflow port exists.
  - Carry-into-MSB is registered on the final chunk.
  - Overflow is valid while out_valid=1.
- ADDER_SEQ_OVF_EN undefined:
  - Overflow port and its logic are absent.
  - All other behaviour and timing are identical.

## Structure
- Shared package adder_pkg:
  - State enum (IDLE/RUN/DONE).
  - Helper for the chunk-count localparam.
  - Elaboration check that WIDTH % CHUNK == 0.
- Sub-module adder_chunk:
  - Combinational CHUNK-bit ripple adder.
  - Inputs a, b, cin.
  - Outputs sum, cout, c_msb (carry into its top bit).
  - Instantiated once and reused every RUN cycle.
- Top level holds the FSM, operand/result shift registers, idx counter and handshake.

## Test plan
- WIDTH=32, CHUNK=4: A=0x0000_0001, B=0xFFFF_FFFF, C0=0, SUB=0 -> SUM=0, Cout=1, Overflow=0; out_valid rises 8 cycles after accept.
- A=0x7FFF_FFFF, B=0x0000_0001, SUB=0 -> SUM=0x8000_0000, Cout=0, Overflow=1 (macro on); with the macro off, the same SUM and Cout.
- SUB=1, A=5, B=7, C0=1 (C0 is ignored) -> SUM=0xFFFF_FFFE, Cout=0, Overflow=0.
- Hold out_ready=0 for 5 cycles in DONE while pulsing in_valid -> SUM, Cout and Overflow are stable, in_ready=0, and no second operation is captured.
- Assert rst during RUN at idx=3 -> out_valid=0, in_ready=1, SUM=0 immediately; the next operation completes correctly.
- WIDTH=CHUNK=4: A=0x8, B=0x8, SUB=0, C0=0 -> SUM=0x0, Cout=1, Overflow=1; out_valid rises 1 cycle after accept.
